// File: rtl/rtc_pkg.sv
// Shared types, limits and helpers for the BCD real-time clock.
// A time value is six packed BCD digits, most significant hour digit first.
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } rtc_time_t;

    localparam logic [7:0] HOUR_MAX  = 8'h23;  // BCD-encoded, compared as two digits
    localparam bcd_t       TENS_MAX  = 4'd5;
    localparam bcd_t       DIGIT_MAX = 4'd9;

    // 24-hour BCD hour to 12-hour BCD hour: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [7:0] to_12h(input bcd_t h1, input bcd_t h0);
        logic [4:0] hb;
        logic [4:0] r;
        hb = {1'b0, h1} * 5'd10 + {1'b0, h0};
        if (hb == 5'd0) begin
            r = 5'd12;
        end else if (hb > 5'd12) begin
            r = hb - 5'd12;
        end else begin
            r = hb;
        end
        if (r >= 5'd10) begin
            return {4'd1, r[3:0] - 4'd10};
        end
        return {4'd0, r[3:0]};
    endfunction

    // Hour and minute fields only; used on its own for the alarm register.
    function automatic logic is_valid_hm(input rtc_time_t t);
        return (t.h0 <= DIGIT_MAX) && ({t.h1, t.h0} <= HOUR_MAX) &&
               (t.m1 <= TENS_MAX) && (t.m0 <= DIGIT_MAX);
    endfunction

    function automatic logic is_valid_time(input rtc_time_t t);
        return is_valid_hm(t) && (t.s1 <= TENS_MAX) && (t.s0 <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// One seven-segment digit: 4-bit value to {g..a} pattern, with blanking.
// Patterns are built active-high and inverted at the output for active-low boards.
module bcd_seg_decode #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] lit;
    logic [6:0] on;

    // NOTE: every path through a combinational block assigns its outputs (here via default), so no latch is inferred.
    always_comb begin
        case (value)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            default: lit = 7'h71;
        endcase
    end

    assign on  = blank ? 7'h00 : lit;
    assign seg = ACTIVE_LOW ? ~on : on;

endmodule

// File: rtl/rtc_bcd_alarm.sv
// BCD 24-hour real-time clock with 1 Hz divider, validated loads, HH:MM alarm
// latch and six directly driven seven-segment digits (optional 12-hour display).
module rtc_bcd_alarm
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        run,
    input  logic        set,
    input  logic        alarm_set,
    input  logic [23:0] time_in,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    input  logic        mode12,
    output logic [23:0] time_out,
    output logic        tick,
    output logic        alarm,
    output logic        pm,
    output logic        load_err,
    output logic [6:0]  HH,
    output logic [6:0]  hh,
    output logic [6:0]  MM,
    output logic [6:0]  mm,
    output logic [6:0]  SS,
    output logic [6:0]  ss
);

    localparam int unsigned      DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    rtc_time_t        cur;
    rtc_time_t        nxt;
    rtc_time_t        load_val;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      alarm_hm;
    logic             time_ok;
    logic             alarm_ok;
    logic             advance;
    logic             trigger;
    logic [7:0]       disp_h;
    logic             blank_h1;

    assign load_val = rtc_time_t'(time_in);
    assign time_ok  = is_valid_time(load_val);
    assign alarm_ok = is_valid_hm(load_val);

    assign tick    = run && (div_cnt == DIV_LAST);
    // A set in the tick cycle owns the time register, so the second is dropped.
    assign advance = tick && !set;
    assign trigger = advance && alarm_en && (nxt.s1 == 4'd0) && (nxt.s0 == 4'd0) &&
                     ({nxt.h1, nxt.h0, nxt.m1, nxt.m0} == alarm_hm);

    always_comb begin
        nxt = cur;
        if (cur.s0 != DIGIT_MAX) begin
            nxt.s0 = cur.s0 + 4'd1;
        end else begin
            nxt.s0 = 4'd0;
            if (cur.s1 != TENS_MAX) begin
                nxt.s1 = cur.s1 + 4'd1;
            end else begin
                nxt.s1 = 4'd0;
                if (cur.m0 != DIGIT_MAX) begin
                    nxt.m0 = cur.m0 + 4'd1;
                end else begin
                    nxt.m0 = 4'd0;
                    if (cur.m1 != TENS_MAX) begin
                        nxt.m1 = cur.m1 + 4'd1;
                    end else begin
                        nxt.m1 = 4'd0;
                        if ({cur.h1, cur.h0} == HOUR_MAX) begin
                            nxt.h1 = 4'd0;
                            nxt.h0 = 4'd0;
                        end else if (cur.h0 == DIGIT_MAX) begin
                            nxt.h1 = cur.h1 + 4'd1;
                            nxt.h0 = 4'd0;
                        end else begin
                            nxt.h0 = cur.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            cur      <= '0;
            alarm_hm <= '0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= (set && !time_ok) || (alarm_set && !alarm_ok);

            // A valid load also realigns the divider so the next second is a full one.
            if (set && time_ok) begin
                cur     <= load_val;
                div_cnt <= '0;
            end else begin
                if (advance) begin
                    cur <= nxt;
                end
                if (run) begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                end
            end

            if (alarm_set && alarm_ok) begin
                alarm_hm <= time_in[23:8];
            end

            if (trigger) begin
                alarm <= 1'b1;
            end else if (alarm_ack || !alarm_en) begin
                alarm <= 1'b0;
            end
        end
    end

    assign time_out = cur;
    assign pm       = ({cur.h1, cur.h0} >= 8'h12);

    assign disp_h   = mode12 ? to_12h(cur.h1, cur.h0) : {cur.h1, cur.h0};
    assign blank_h1 = mode12 && (disp_h[7:4] == 4'd0);

    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_h1 (.value(disp_h[7:4]), .blank(blank_h1), .seg(HH));
    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_h0 (.value(disp_h[3:0]), .blank(1'b0),     .seg(hh));
    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_m1 (.value(cur.m1),      .blank(1'b0),     .seg(MM));
    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_m0 (.value(cur.m0),      .blank(1'b0),     .seg(mm));
    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_s1 (.value(cur.s1),      .blank(1'b0),     .seg(SS));
    bcd_seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_s0 (.value(cur.s0),      .blank(1'b0),     .seg(ss));

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// Directed bench for rtc_bcd_alarm at CLK_HZ=4: a seconds-since-midnight model
// is compared every cycle, plus hand-computed literals for each scenario.
module tb_rtc_bcd_alarm;

    localparam int CLK_HZ = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        run = 1'b0;
    logic        set = 1'b0;
    logic        alarm_set = 1'b0;
    logic [23:0] time_in = '0;
    logic        alarm_en = 1'b0;
    logic        alarm_ack = 1'b0;
    logic        mode12 = 1'b0;
    logic [23:0] time_out;
    logic        tick;
    logic        alarm;
    logic        pm;
    logic        load_err;
    logic [6:0]  HH, hh, MM, mm, SS, ss;

    int errors = 0;
    int checks = 0;

    // Model state: time as seconds since midnight, alarm as minutes since midnight.
    int m_secs = 0;
    int m_phase = 0;
    int m_alarm_min = 0;
    bit m_alarm = 1'b0;
    bit m_lerr = 1'b0;
    bit m_tick, m_vt, m_va, m_trig;
    int c_h, c_dh, c_m, c_s;
    logic [23:0] held;

    // Active-low {g..a} patterns for hex digits 0..F.
    logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 CLK = ~CLK;

    rtc_bcd_alarm #(.CLK_HZ(CLK_HZ), .SEG_ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK), .reset(reset), .run(run), .set(set), .alarm_set(alarm_set),
        .time_in(time_in), .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode12(mode12),
        .time_out(time_out), .tick(tick), .alarm(alarm), .pm(pm), .load_err(load_err),
        .HH(HH), .hh(hh), .MM(MM), .mm(mm), .SS(SS), .ss(ss)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dig(input logic [23:0] v, input int i);
        return int'((v >> (4 * i)) & 24'hF);
    endfunction

    function automatic bit valid_load(input logic [23:0] v, input bit with_sec);
        for (int i = (with_sec ? 0 : 2); i < 6; i++) begin
            if (dig(v, i) > 9) return 1'b0;
        end
        if (dig(v, 5) * 10 + dig(v, 4) > 23) return 1'b0;
        if (dig(v, 3) > 5) return 1'b0;
        if (with_sec && dig(v, 1) > 5) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_secs(input logic [23:0] v);
        return (dig(v, 5) * 10 + dig(v, 4)) * 3600 + (dig(v, 3) * 10 + dig(v, 2)) * 60 +
               dig(v, 1) * 10 + dig(v, 0);
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d, input bit blank);
        return blank ? 7'h7F : seg_al[d];
    endfunction

    // Behavioural model, advanced on the same edges as the DUT.
    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_secs = 0;
            m_phase = 0;
            m_alarm_min = 0;
            m_alarm = 1'b0;
            m_lerr = 1'b0;
        end else begin
            m_tick = run && (m_phase == CLK_HZ - 1);
            m_vt = valid_load(time_in, 1'b1);
            m_va = valid_load(time_in, 1'b0);
            m_trig = 1'b0;
            m_lerr = (set && !m_vt) || (alarm_set && !m_va);
            if (set && m_vt) begin
                m_secs = to_secs(time_in);
                m_phase = 0;
            end else begin
                if (m_tick && !set) begin
                    m_secs = (m_secs + 1) % 86400;
                    m_trig = alarm_en && (m_secs % 60 == 0) && (m_secs / 60 == m_alarm_min);
                end
                if (run) m_phase = (m_phase + 1) % CLK_HZ;
            end
            if (alarm_set && m_va)
                m_alarm_min = (dig(time_in, 5) * 10 + dig(time_in, 4)) * 60 +
                              dig(time_in, 3) * 10 + dig(time_in, 2);
            if (m_trig) m_alarm = 1'b1;
            else if (alarm_ack || !alarm_en) m_alarm = 1'b0;
        end
    end

    // Per-cycle comparison, half a period away from the active edge.
    always @(negedge CLK) begin
        c_h = m_secs / 3600;
        c_m = (m_secs / 60) % 60;
        c_s = m_secs % 60;
        c_dh = !mode12 ? c_h : (c_h == 0) ? 12 : (c_h > 12) ? c_h - 12 : c_h;
        check("cyc_time_out", time_out, to_bcd(m_secs));
        check("cyc_tick", tick, reset && run && (m_phase == CLK_HZ - 1));
        check("cyc_alarm", alarm, m_alarm);
        check("cyc_pm", pm, c_h >= 12);
        check("cyc_load_err", load_err, m_lerr);
        check("cyc_HH", HH, seg_of(c_dh / 10, mode12 && c_dh < 10));
        check("cyc_hh", hh, seg_of(c_dh % 10, 1'b0));
        check("cyc_MM", MM, seg_of(c_m / 10, 1'b0));
        check("cyc_mm", mm, seg_of(c_m % 10, 1'b0));
        check("cyc_SS", SS, seg_of(c_s / 10, 1'b0));
        check("cyc_ss", ss, seg_of(c_s % 10, 1'b0));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_set(input logic [23:0] v);
        set = 1'b1;
        time_in = v;
        cyc(1);
        set = 1'b0;
    endtask

    // Returns at the falling edge where tick is high; a missing tick is a failed check.
    task automatic wait_tick_neg(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * CLK_HZ && !seen; k++) begin
            @(negedge CLK);
            seen = tick;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_tick(input string name);
        wait_tick_neg(name);
        cyc(1);
    endtask

    // Counts cycles from now up to and including the one carrying tick.
    task automatic ticks_after(input string name, input int exp);
        int k;
        k = 0;
        for (int i = 1; i <= 4 * CLK_HZ; i++) begin
            @(negedge CLK);
            if (tick) begin
                k = i;
                break;
            end
        end
        check(name, k, exp);
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        run = 1'b1;
        #1;
        check("rst_time_out", time_out, 24'h000000);
        check("rst_alarm", alarm, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_HH", HH, 7'h40);
        mode12 = 1'b1;
        #1;
        check("rst_m12_HH", HH, 7'h79);
        check("rst_m12_hh", hh, 7'h24);
        mode12 = 1'b0;
        cyc(3);
        reset = 1'b1;
        ticks_after("first_tick", 4);

        // Rollover through midnight
        do_set(24'h235958);
        check("roll_load", time_out, 24'h235958);
        check("roll_pm_hi", pm, 1'b1);
        check("roll_no_err", load_err, 1'b0);
        wait_tick("roll_t1");
        check("roll_59", time_out, 24'h235959);
        wait_tick("roll_t2");
        check("roll_zero", time_out, 24'h000000);
        check("roll_pm_lo", pm, 1'b0);

        // Invalid loads
        held = time_out;
        do_set(24'h240000);
        check("bad_hour_err", load_err, 1'b1);
        check("bad_hour_hold", time_out, held);
        cyc(1);
        check("bad_hour_pulse", load_err, 1'b0);
        held = time_out;
        do_set(24'h126A00);
        check("bad_min_err", load_err, 1'b1);
        check("bad_min_hold", time_out, held);
        cyc(1);
        check("bad_min_pulse", load_err, 1'b0);
        alarm_set = 1'b1;
        time_in = 24'h250000;
        cyc(1);
        alarm_set = 1'b0;
        check("bad_alarm_err", load_err, 1'b1);
        set = 1'b1;
        alarm_set = 1'b1;
        time_in = 24'h123460;
        cyc(1);
        set = 1'b0;
        alarm_set = 1'b0;
        check("or_err", load_err, 1'b1);
        do_set(24'h123456);
        check("good_load", time_out, 24'h123456);
        check("good_no_err", load_err, 1'b0);
        ticks_after("realign", 4);

        // Set coincident with a tick, then pause
        wait_tick_neg("conflict_tick");
        set = 1'b1;
        time_in = 24'h100000;
        @(posedge CLK);
        #1;
        set = 1'b0;
        check("conflict", time_out, 24'h100000);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("pause_tick", tick, 1'b0);
        end
        cyc(1);
        check("pause_frozen", time_out, 24'h100000);
        run = 1'b1;

        // 12-hour display
        mode12 = 1'b1;
        do_set(24'h001500);
        check("m12a_HH", HH, 7'h79);
        check("m12a_hh", hh, 7'h24);
        check("m12a_MM", MM, 7'h79);
        check("m12a_mm", mm, 7'h12);
        check("m12a_pm", pm, 1'b0);
        do_set(24'h130500);
        check("m12b_HH", HH, 7'h7F);
        check("m12b_hh", hh, 7'h79);
        check("m12b_MM", MM, 7'h40);
        check("m12b_mm", mm, 7'h12);
        check("m12b_pm", pm, 1'b1);
        check("m12b_time", time_out, 24'h130500);
        mode12 = 1'b0;

        // Alarm
        alarm_set = 1'b1;
        time_in = 24'h073000;
        cyc(1);
        alarm_set = 1'b0;
        check("alarm_load_ok", load_err, 1'b0);
        alarm_en = 1'b1;
        do_set(24'h073000);
        check("load_no_trigger", alarm, 1'b0);
        do_set(24'h072959);
        wait_tick("alarm_tick");
        check("alarm_time", time_out, 24'h073000);
        check("alarm_rise", alarm, 1'b1);
        cyc(8);
        check("alarm_hold", alarm, 1'b1);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        check("alarm_ack_clr", alarm, 1'b0);
        do_set(24'h072959);
        wait_tick_neg("retrig_tick");
        alarm_ack = 1'b1;
        @(posedge CLK);
        #1;
        alarm_ack = 1'b0;
        check("retrig_wins", alarm, 1'b1);
        check("retrig_time", time_out, 24'h073000);

        // Reset in the middle of a cycle with the alarm latched
        #2;
        reset = 1'b0;
        #1;
        check("midrst_time", time_out, 24'h000000);
        check("midrst_alarm", alarm, 1'b0);
        check("midrst_tick", tick, 1'b0);
        cyc(2);
        reset = 1'b1;
        ticks_after("midrst_first_tick", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_alarm.md
# rtc_bcd_alarm

Parametrised BCD real-time-clock core: the next generation of the board-level 24-hour clock. It generates an exact 1 Hz tick from `CLK`, keeps HH:MM:SS in BCD, validates loads, offers a 12/24-hour display mode, a run/pause control and a latched HH:MM alarm. It drives six seven-segment digits directly and sits between board switches/keys and the HEX displays.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: `CLK` cycles per second; must be ≥ 2.
- `SEG_ACTIVE_LOW`, 1: 1 gives active-low segments (0 = lit); 0 inverts all segment outputs.

Ports:
- `CLK`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = divider counts; 0 = divider and time hold.
- `set`  in  1  load time from `time_in` (level, sampled every cycle).
- `alarm_set`  in  1  load alarm HH:MM from `time_in[23:8]`.
- `time_in`  in  24  BCD {H1,H0,M1,M0,S1,S0}.
- `alarm_en`  in  1  alarm enable.
- `alarm_ack`  in  1  clears a latched alarm.
- `mode12`  in  1  1 = 12-hour display.
- `time_out`  out  24  current time, BCD, always 24-hour.
- `tick`  out  1  one-cycle pulse per second.
- `alarm`  out  1  latched alarm flag.
- `pm`  out  1  1 when hour ≥ 12, independent of mode.
- `load_err`  out  1  one-cycle pulse on a rejected load.
- `HH, hh, MM, mm, SS, ss`  out  7 each  segment patterns {g..a}.

## Operation
- Divider: `div_cnt` counts 0..CLK_HZ-1 while `run`=1 and wraps to 0. `tick`=1 in the cycle where `div_cnt`==CLK_HZ-1 and `run`=1. While `run`=0, `div_cnt` holds and `tick`=0.
- Advance on `tick`: seconds +1 in BCD. S0 9→0 carries to S1. S1 5→0 carries to minutes, same for minutes. 23:59:59 → 00:00:00.
- Load validity: every nibble ≤ 9, hour ≤ 23, M1 ≤ 5, S1 ≤ 5. The alarm load checks only HH:MM.
- Time load: on `set`, a valid `time_in` loads the time and clears `div_cnt` to 0 (phase realign). An invalid value leaves the time unchanged and pulses `load_err`.
- Alarm load: `alarm_set` loads the alarm register on a valid value. An invalid value is rejected and pulses `load_err`.
- Priority, same cycle: `set` beats `tick`, so the tick is discarded and the loaded value wins. `set` and `alarm_set` both act, and `load_err` ORs the two checks.
- Alarm trigger: occurs when a tick advance produces HH:MM:00 equal to the alarm register with `alarm_en`=1. A load never triggers.
- Alarm latch: `alarm` stays set until `alarm_ack`=1 or `alarm_en`=0. If a trigger and `alarm_ack` fall in the same cycle, the trigger wins.
- 12-hour display (`mode12`=1, digits only): hour 00→12, 01–11 unchanged, 12→12, 13–23 → hour−12. The result is in BCD, and a leading-zero H1 is blanked (all segments off). `time_out` is unaffected.
- Segment map per digit 0–F follows the team's standard HEX encoding.

## Timing
- Reset (asynchronous assert, synchronous-clock release) sets:
  - `div_cnt`=0, time 00:00:00, alarm register 00:00;
  - `alarm`=0, `tick`=0, `load_err`=0;
  - `time_out`=0 and all digits showing "0". In mode12 the display shows "12", because it is combinational from the time register.
- `tick`, `pm` and the segment outputs are combinational from registers. `load_err` is a registered pulse, 1 cycle after the `set`/`alarm_set` cycle.
- Latencies, all 1 cycle:
  - `time_out` updates on the edge ending the tick cycle.
  - A load is visible on the edge ending the `set` cycle.
  - `alarm` rises together with the matching `time_out` update.
- Reset asserted mid-count or mid-alarm: immediate return to reset values; no tick is emitted.
- CLK_HZ=2: `tick` every second cycle.

## Structure
- Shared package `rtc_pkg`:
  - BCD digit type and packed time struct {h1,h0,m1,m0,s1,s0};
  - limit constants (23, 5, 9);
  - 12-hour conversion function;
  - validity function.
- Sub-module `bcd_seg_decode`: 4-bit value plus blank in, 7-bit pattern out, polarity parameter. Instantiated six times.
- The divider, time counter, and alarm compare/latch all live in `rtc_bcd_alarm`.

## Test plan
All scenarios use CLK_HZ=4.
- Reset mid-run: assert `reset`=0 at arbitrary phase → `time_out`=000000 and `alarm`=0 immediately. After release, the first `tick` comes 4 cycles later.
- Rollover: load 23:59:58 → after two ticks `time_out`=000000 and `pm` goes 1→0.
- Invalid loads: `set` with 24:00:00 and with 12:6A:00 → time unchanged and `load_err` pulses once each. A valid 12:34:56 loads next cycle with `div_cnt`=0.
- Same-cycle conflict and pause: `set` of 10:00:00 in a tick cycle → `time_out`=100000, not 100001. `run`=0 for 20 cycles → no tick and time frozen.
- 12-hour display with mode12=1:
  - 00:15:00 → digits "12 15 00", `pm`=0;
  - 13:05:00 → " 1 05 00", `pm`=1, `time_out`=130500.
- Alarm:
  - alarm 07:30, load 07:29:59, `alarm_en`=1 → `alarm` rises with 073000 and holds;
  - `alarm_ack` clears it;
  - a re-trigger coincident with `alarm_ack` leaves `alarm`=1.
